ram_512x8: RTL and testbench



---
 rtl/ram_512x8_pkg.sv | 20 ++
 rtl/ram_512x8_lane.sv | 54 +++++
 rtl/ram_512x8.sv | 131 +++++++++++++
 tb/tb_ram_512x8.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_512x8_pkg.sv
// Shared encodings for the 512x8 byte-addressable data memory.
// Optional build macro: RAM_CLEAR_ON_RESET_EN (see ram_512x8.sv).
package ram_512x8_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ram_512x8_lane.sv
// Byte-lane steering: wrapped lane addresses, write enables and big-endian
// read assembly. Lane 0 is the byte at the effective address (bus MSB side).
module ram_512x8_lane
  import ram_512x8_pkg::*;
(
  input  logic [8:0]  adr,
  input  logic [1:0]  place,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rbytes,
  output logic [35:0] addrs,
  output logic [3:0]  we_mask,
  output logic [31:0] wbytes,
  output logic [31:0] rdata
);

  logic [8:0] ea;

  // 9-bit addition wraps naturally from 511 back to 0
  assign ea = adr + {7'b0, place};

  for (genvar gi = 0; gi < 4; gi++) begin : g_addr
    assign addrs[9*gi +: 9] = ea + 9'(gi);
  end

  always_comb begin
    we_mask = 4'b0000;
    wbytes  = 32'h0;
    rdata   = 32'h0;
    case (size)
      SZ_BYTE: begin
        we_mask = 4'b0001;
        wbytes  = {wdata[7:0], 24'h0};
        rdata   = {24'h0, rbytes[31:24]};
      end
      SZ_HALF: begin
        we_mask = 4'b0011;
        wbytes  = {wdata[15:0], 16'h0};
        rdata   = {16'h0, rbytes[31:16]};
      end
      SZ_WORD: begin
        we_mask = 4'b1111;
        wbytes  = wdata;
        rdata   = rbytes;
      end
      default: begin
        we_mask = 4'b0000;
        wbytes  = 32'h0;
        rdata   = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/ram_512x8.sv
// 512-byte data memory with request/finished handshake and LATENCY-cycle access.
// Build macro RAM_CLEAR_ON_RESET_EN: reset also clears every byte to 0x00.
module ram_512x8
  import ram_512x8_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] out,
  output logic        finished,
  input  logic        en,
  input  logic        rw,
  input  logic [8:0]  adr,
  input  logic [31:0] data,
  input  logic [1:0]  dataSize,
  input  logic [1:0]  dataPlace
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            rw_reg;
  logic [8:0]      adr_reg;
  logic [31:0]     data_reg;
  logic [1:0]      size_reg;
  logic [1:0]      place_reg;
  logic [31:0]     out_reg;
  logic            finished_reg;

  logic [7:0]      mem [0:DEPTH-1];

  logic [35:0]     addrs;
  logic [3:0]      we_mask;
  logic [31:0]     wbytes;
  logic [31:0]     rbytes;
  logic [31:0]     rdata;
  logic            complete;
  logic            do_write;

  ram_512x8_lane u_lane (
    .adr     (adr_reg),
    .place   (place_reg),
    .size    (size_reg),
    .wdata   (data_reg),
    .rbytes  (rbytes),
    .addrs   (addrs),
    .we_mask (we_mask),
    .wbytes  (wbytes),
    .rdata   (rdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    assign rbytes[31-8*gi -: 8] = mem[addrs[9*gi +: 9]];
  end

  assign complete = (state_reg == BUSY) && (cnt_reg == '0);
  assign do_write = complete && (rw_reg == RW_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rw_reg       <= RW_READ;
      adr_reg      <= '0;
      data_reg     <= '0;
      size_reg     <= SZ_BYTE;
      place_reg    <= '0;
      out_reg      <= '0;
      finished_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          finished_reg <= 1'b0;
          if (en) begin
            rw_reg    <= rw;
            adr_reg   <= adr;
            data_reg  <= data;
            size_reg  <= dataSize;
            place_reg <= dataPlace;
            cnt_reg   <= CNT_LOAD;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            finished_reg <= 1'b1;
            if (rw_reg == RW_READ) out_reg <= rdata;
            state_reg <= DONE;
          end
        end
        DONE: begin
          finished_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          finished_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  // Writes commit only on the completing edge, so a reset in BUSY drops them
`ifdef RAM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (do_write) begin
      for (int i = 0; i < 4; i++)
        if (we_mask[i]) mem[addrs[9*i +: 9]] <= wbytes[31-8*i -: 8];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++)
        if (we_mask[i]) mem[addrs[9*i +: 9]] <= wbytes[31-8*i -: 8];
    end
  end
`endif

  assign out      = out_reg;
  assign finished = finished_reg;

endmodule

// File: tb/tb_ram_512x8.sv
// Scoreboard bench for ram_512x8: LATENCY=1 instance for data paths,
// LATENCY=3 instance for handshake timing.
module tb_ram_512x8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, en3 = 1'b0;
  logic        rw = 1'b1;
  logic [8:0]  adr = '0;
  logic [31:0] data = '0;
  logic [1:0]  dataSize = 2'b00, dataPlace = 2'b00;
  logic [31:0] out, out3;
  logic        finished, finished3;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] exp;
    bit          care;
    string       tag;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  logic [7:0]  mdl  [2][512];
  bit          mval [2][512];
  logic [31:0] last_out [2];
  bit          last_care [2];

  always #5 clk = ~clk;

  ram_512x8 #(.DEPTH(512), .LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .out(out), .finished(finished), .en(en), .rw(rw),
    .adr(adr), .data(data), .dataSize(dataSize), .dataPlace(dataPlace)
  );

  ram_512x8 #(.DEPTH(512), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .out(out3), .finished(finished3), .en(en3), .rw(rw),
    .adr(adr), .data(data), .dataSize(dataSize), .dataPlace(dataPlace)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int w, input logic [8:0] a,
      input logic [1:0] sz, input logic [1:0] pl, output bit care);
    logic [31:0] v;
    int idx;
    v = 32'h0;
    care = 1'b1;
    for (int k = 0; k < nbytes(sz); k++) begin
      idx = (int'(a) + int'(pl) + k) % 512;
      if (!mval[w][idx]) care = 1'b0;
      v = (v << 8) | {24'h0, mdl[w][idx]};
    end
    return v;
  endfunction

  task automatic model_write(input int w, input logic [8:0] a, input logic [31:0] d,
      input logic [1:0] sz, input logic [1:0] pl);
    int idx;
    int nb;
    logic [31:0] sh;
    nb = nbytes(sz);
    for (int k = 0; k < nb; k++) begin
      idx = (int'(a) + int'(pl) + k) % 512;
      sh = d >> (8 * (nb - 1 - k));
      mdl[w][idx] = sh[7:0];
      mval[w][idx] = 1'b1;
    end
  endtask

  task automatic push(input int w, input sb_t e);
    if (w == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Expected out after a completion: read value, or the held value for writes
  task automatic expect_access(input int w, input bit r, input logic [8:0] a,
      input logic [31:0] d, input logic [1:0] sz, input logic [1:0] pl, input string tag);
    sb_t e;
    bit c;
    e.tag = tag;
    if (r) begin
      e.exp = model_read(w, a, sz, pl, c);
      e.care = c;
      last_out[w] = e.exp;
      last_care[w] = c;
    end else begin
      model_write(w, a, d, sz, pl);
      e.exp = last_out[w];
      e.care = last_care[w];
    end
    push(w, e);
  endtask

  function automatic logic fin(input int w);
    return (w == 0) ? finished : finished3;
  endfunction

  task automatic access(input int w, input bit r, input logic [8:0] a, input logic [31:0] d,
      input logic [1:0] sz, input logic [1:0] pl, input string tag);
    int n;
    int lat;
    lat = (w == 0) ? 1 : 3;
    expect_access(w, r, a, d, sz, pl, tag);
    @(negedge clk);
    rw = r; adr = a; data = d; dataSize = sz; dataPlace = pl;
    if (w == 0) en = 1'b1; else en3 = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; en3 = 1'b0;
    check({tag, "_fin_low_at_accept"}, {31'h0, fin(w)}, 32'h0);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (fin(w)) begin n = i; break; end
    end
    check({tag, "_latency"}, n, lat);
    @(posedge clk); #1;
    check({tag, "_fin_one_cycle"}, {31'h0, fin(w)}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (finished) begin
      if (q0.size() == 0) begin
        check("dut_unexpected_finished", 32'h1, 32'h0);
      end else begin
        sb_t e;
        e = q0.pop_front();
        if (e.care) check(e.tag, out, e.exp);
        $display("dut  %s out=%h", e.tag, out);
      end
    end
  end

  always @(negedge clk) begin
    if (finished3) begin
      if (q1.size() == 0) begin
        check("dut3_unexpected_finished", 32'h1, 32'h0);
      end else begin
        sb_t e;
        e = q1.pop_front();
        if (e.care) check(e.tag, out3, e.exp);
        $display("dut3 %s out=%h", e.tag, out3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1;
    int g;
    sb_t e;
    bit c;

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 512; i++) begin
`ifdef RAM_CLEAR_ON_RESET_EN
        mdl[w][i] = 8'h00; mval[w][i] = 1'b1;
`else
        mdl[w][i] = 8'h00; mval[w][i] = 1'b0;
`endif
      end
      last_out[w] = 32'h0;
      last_care[w] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_finished", {31'h0, finished}, 32'h0);
    check("reset_out3", out3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Byte writes then reads (place 3 never written)
    access(0, 0, 9'd0, 32'h03, 2'b00, 2'd2, "wr_b_p2");
    access(0, 0, 9'd0, 32'h04, 2'b00, 2'd1, "wr_b_p1");
    access(0, 0, 9'd0, 32'h05, 2'b00, 2'd0, "wr_b_p0");
    access(0, 1, 9'd0, 32'h0,  2'b00, 2'd1, "rd_b_p1");
    access(0, 1, 9'd0, 32'h0,  2'b00, 2'd2, "rd_b_p2");
    access(0, 1, 9'd0, 32'h0,  2'b00, 2'd3, "rd_b_p3");
    access(0, 1, 9'd0, 32'h0,  2'b00, 2'd0, "rd_b_p0");

    // Halfword, upper data bits must be ignored
    access(0, 0, 9'd0, 32'hFFFFABCD, 2'b01, 2'd2, "wr_h_p2");
    access(0, 1, 9'd0, 32'h0, 2'b01, 2'd2, "rd_h_p2");
    access(0, 1, 9'd0, 32'h0, 2'b00, 2'd3, "rd_b_p3_cd");

    // Word
    access(0, 0, 9'd0, 32'h12345678, 2'b10, 2'd0, "wr_w_0");
    access(0, 1, 9'd0, 32'h0, 2'b10, 2'd0, "rd_w_0");
    access(0, 1, 9'd0, 32'h0, 2'b00, 2'd0, "rd_b_0");

    // Wrap across 511 -> 0
    access(0, 0, 9'd510, 32'hDEADBEEF, 2'b10, 2'd1, "wr_w_wrap");
    access(0, 1, 9'd510, 32'h0, 2'b10, 2'd1, "rd_w_wrap");
    access(0, 1, 9'd1, 32'h0, 2'b01, 2'd0, "rd_h_1");

    // Reserved size: read gives 0, write is a no-op
    access(0, 1, 9'd511, 32'h0, 2'b11, 2'd0, "rd_rsv");
    access(0, 1, 9'd1, 32'h0, 2'b01, 2'd0, "rd_h_1_again");
    access(0, 0, 9'd511, 32'hFFFFFFFF, 2'b11, 2'd0, "wr_rsv");
    access(0, 1, 9'd511, 32'h0, 2'b10, 2'd0, "rd_w_after_rsv");

    // Reset during a BUSY write: byte must keep its old value
    access(0, 0, 9'd5, 32'h11, 2'b00, 2'd0, "wr_b_5");
    @(negedge clk);
    rw = 1'b0; adr = 9'd5; data = 32'h77; dataSize = 2'b00; dataPlace = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 32'h0);
    check("abort_finished", {31'h0, finished}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 2; w++) begin
      last_out[w] = 32'h0;
      last_care[w] = 1'b1;
`ifdef RAM_CLEAR_ON_RESET_EN
      for (int i = 0; i < 512; i++) begin mdl[w][i] = 8'h00; mval[w][i] = 1'b1; end
`endif
    end
    @(posedge clk); #1;
    check("abort_no_finish", {31'h0, finished}, 32'h0);
    access(0, 1, 9'd5, 32'h0, 2'b00, 2'd0, "rd_b_5_after_abort");

    // LATENCY=3 instance
    access(1, 0, 9'd100, 32'hCAFEF00D, 2'b10, 2'd0, "l3_wr_100");
    access(1, 0, 9'd200, 32'h01020304, 2'b10, 2'd0, "l3_wr_200");
    access(1, 1, 9'd100, 32'h0, 2'b10, 2'd0, "l3_rd_100");

    // Continuous en with adr toggled during BUSY
    e.tag = "l3_cont_rd1"; e.exp = model_read(1, 9'd100, 2'b10, 2'd0, c); e.care = c;
    q1.push_back(e);
    e.tag = "l3_cont_rd2";
    q1.push_back(e);
    @(negedge clk);
    rw = 1'b1; adr = 9'd100; dataSize = 2'b10; dataPlace = 2'd0; en3 = 1'b1;
    @(posedge clk); #1;
    adr = 9'd200;
    f1 = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (finished3) begin f1 = i; break; end
    end
    check("l3_cont_first_latency", f1, 3);
    adr = 9'd100;
    g = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) adr = 9'd200;
      if (finished3) begin g = i; break; end
    end
    check("l3_cont_repeat_period", g, 5);
    en3 = 1'b0;
    g = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (finished3) g++;
    end
    check("l3_no_extra_pulse", g, 0);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
